// File: rtl/bornes_d_vers_bcd_seq_if.sv
// Request/result bundle between the bounds-selection logic and the
// die-type-to-BCD converter.
interface bornes_d_vers_bcd_seq_if #(
    parameter int unsigned W_IN     = 7,
    parameter int unsigned N_DIGITS = 3
);
    logic                    start;
    logic [W_IN-1:0]         d_min;
    logic [W_IN-1:0]         d_max;
    logic                    busy;
    logic                    done;
    logic                    err;
    logic [4*N_DIGITS-1:0]   bcd;
    logic [N_DIGITS-1:0]     en;

    modport master (
        output start, d_min, d_max,
        input  busy, done, err, bcd, en
    );

    modport slave (
        input  start, d_min, d_max,
        output busy, done, err, bcd, en
    );
endinterface

// File: rtl/bornes_d_vers_bcd_seq.sv
// Die bounds to display digits: die type = d_max + 1 - d_min, converted to BCD
// by serial double-dabble, with leading-zero blanking enables and error flag.
module bornes_d_vers_bcd_seq #(
    parameter int unsigned W_IN     = 7,
    parameter int unsigned N_DIGITS = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    bornes_d_vers_bcd_seq_if.slave   bus
);
    localparam int unsigned RW = W_IN + 1;
    localparam int unsigned BW = 4 * N_DIGITS;
    localparam int unsigned CW = $clog2(RW + 1);

    typedef enum logic [1:0] {IDLE, CALC, SHIFT, FIN} state_t;

    state_t          state_q, state_d;
    logic [W_IN-1:0] dmin_q, dmin_d;
    logic [W_IN-1:0] dmax_q, dmax_d;
    logic [RW-1:0]   range_q, range_d;
    logic [BW-1:0]   sh_q, sh_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            flag_q, flag_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [BW-1:0]   bcd_q, bcd_d;
    logic [N_DIGITS-1:0] en_q, en_d;

    logic [BW-1:0]       adj;
    logic [N_DIGITS-1:0] en_calc;
    logic                last_iter;

    assign last_iter = (cnt_q == CW'(RW - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dmin_q  <= '0;
            dmax_q  <= '0;
            range_q <= '0;
            sh_q    <= '0;
            cnt_q   <= '0;
            flag_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            bcd_q   <= '0;
            en_q    <= '0;
        end else begin
            state_q <= state_d;
            dmin_q  <= dmin_d;
            dmax_q  <= dmax_d;
            range_q <= range_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            flag_q  <= flag_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            bcd_q   <= bcd_d;
            en_q    <= en_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = CALC;
            CALC:    state_d = SHIFT;
            SHIFT:   if (last_iter) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Double-dabble correction: any nibble >= 5 gets +3 before the shift.
    always_comb begin
        adj = sh_q;
        for (int unsigned i = 0; i < N_DIGITS; i++) begin
            if (sh_q[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = sh_q[4*i +: 4] + 4'd3;
        end
    end

    // Digit i is shown when it or any more significant digit is nonzero.
    always_comb begin
        en_calc    = '0;
        en_calc[0] = 1'b1;
        for (int unsigned i = 1; i < N_DIGITS; i++)
            en_calc[i] = |(sh_q >> (4 * i));
    end

    always_comb begin
        dmin_d  = dmin_q;
        dmax_d  = dmax_q;
        range_d = range_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        flag_d  = flag_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;
        bcd_d   = bcd_q;
        en_d    = en_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    dmin_d = bus.d_min;
                    dmax_d = bus.d_max;
                    busy_d = 1'b1;
                end
            end
            CALC: begin
                range_d = ({1'b0, dmax_q} + RW'(1)) - {1'b0, dmin_q};
                flag_d  = (dmin_q > dmax_q);
                sh_d    = '0;
                cnt_d   = '0;
            end
            SHIFT: begin
                sh_d    = {adj[BW-2:0], range_q[RW-1]};
                range_d = {range_q[RW-2:0], 1'b0};
                cnt_d   = cnt_q + CW'(1);
            end
            FIN: begin
                done_d = 1'b1;
                busy_d = 1'b0;
                err_d  = flag_q;
                bcd_d  = flag_q ? '0 : sh_q;
                en_d   = flag_q ? '0 : en_calc;
            end
            default: ;
        endcase
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.err  = err_q;
    assign bus.bcd  = bcd_q;
    assign bus.en   = en_q;
endmodule

// File: tb/tb_bornes_d_vers_bcd_seq.sv
// Bench for bornes_d_vers_bcd_seq: directed table, multi-cycle corner cases and
// random bounds checked against a decimal-arithmetic reference model.
module tb_bornes_d_vers_bcd_seq;
    localparam int unsigned W1 = 7;
    localparam int unsigned N1 = 3;
    localparam int unsigned W2 = 9;
    localparam int unsigned N2 = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    bornes_d_vers_bcd_seq_if #(.W_IN(W1), .N_DIGITS(N1)) bus1 ();
    bornes_d_vers_bcd_seq_if #(.W_IN(W2), .N_DIGITS(N2)) bus2 ();

    bornes_d_vers_bcd_seq #(.W_IN(W1), .N_DIGITS(N1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    bornes_d_vers_bcd_seq #(.W_IN(W2), .N_DIGITS(N2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        int          dmin;
        int          dmax;
        logic [11:0] bcd;
        logic [2:0]  en;
        logic        err;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference: die type in plain integers, digits by repeated /10.
    function automatic void model(input int dmin, input int dmax, input int nd,
                                  output logic [15:0] b, output logic [3:0] e, output logic er);
        int  r;
        bit  seen;
        b    = '0;
        e    = '0;
        er   = (dmin > dmax);
        seen = 1'b0;
        if (!er) begin
            r = dmax - dmin + 1;
            for (int i = 0; i < nd; i++) begin
                b[4*i +: 4] = 4'(r % 10);
                r = r / 10;
            end
            for (int i = nd - 1; i >= 1; i--) begin
                if (b[4*i +: 4] != 4'd0) seen = 1'b1;
                e[i] = seen;
            end
            e[0] = 1'b1;
        end
    endfunction

    // One conversion on dut1; intr>0 fires a second start pulse at that cycle.
    task automatic conv1(input string nm, input int dmin, input int dmax,
                         input logic [11:0] eb, input logic [2:0] ee, input logic er,
                         input int intr);
        int lat;
        int extra;
        lat = 0;
        @(negedge clk);
        bus1.d_min = W1'(dmin);
        bus1.d_max = W1'(dmax);
        bus1.start = 1'b1;
        @(posedge clk); #1;
        check({nm, "_busy_on_accept"}, 32'(bus1.busy), 32'd1);
        bus1.start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (intr > 0 && k == intr + 1) begin
                bus1.d_min = W1'(1);
                bus1.d_max = W1'(6);
                bus1.start = 1'b1;
            end else if (intr > 0 && k == intr + 2) begin
                bus1.start = 1'b0;
            end
            @(posedge clk); #1;
            if (bus1.done) begin
                lat = k;
                break;
            end
        end
        check({nm, "_latency"}, 32'(lat), 32'(W1 + 3));
        check({nm, "_bcd"}, 32'(bus1.bcd), 32'(eb));
        check({nm, "_en"}, 32'(bus1.en), 32'(ee));
        check({nm, "_err"}, 32'(bus1.err), 32'(er));
        check({nm, "_busy_at_done"}, 32'(bus1.busy), 32'd0);
        @(posedge clk); #1;
        check({nm, "_done_one_cycle"}, 32'(bus1.done), 32'd0);
        check({nm, "_bcd_hold"}, 32'(bus1.bcd), 32'(eb));
        if (intr > 0) begin
            extra = 0;
            for (int k = 0; k < 14; k++) begin
                @(posedge clk); #1;
                if (bus1.done || bus1.busy) extra++;
            end
            check({nm, "_no_queued_conv"}, 32'(extra), 32'd0);
            check({nm, "_bcd_after_ignore"}, 32'(bus1.bcd), 32'(eb));
        end
    endtask

    task automatic conv2(input string nm, input int dmin, input int dmax);
        int lat;
        logic [15:0] mb;
        logic [3:0]  me;
        logic        mr;
        model(dmin, dmax, N2, mb, me, mr);
        lat = 0;
        @(negedge clk);
        bus2.d_min = W2'(dmin);
        bus2.d_max = W2'(dmax);
        bus2.start = 1'b1;
        @(negedge clk);
        bus2.start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (k > 1) @(posedge clk);
            if (k > 1) #1;
            if (k == 1) begin
                @(posedge clk); #1;
            end
            if (bus2.done) begin
                lat = k;
                break;
            end
        end
        check({nm, "_latency"}, 32'(lat), 32'(W2 + 3));
        check({nm, "_bcd"}, 32'(bus2.bcd), 32'(mb));
        check({nm, "_en"}, 32'(bus2.en), 32'(me));
        check({nm, "_err"}, 32'(bus2.err), 32'(mr));
    endtask

    initial begin
        vec_t        tbl[$];
        logic [15:0] mb;
        logic [3:0]  me;
        logic        mr;
        int          a, b, t, n_done, n_bad;

        rst_n      = 1'b0;
        bus1.start = 1'b0; bus1.d_min = '0; bus1.d_max = '0;
        bus2.start = 1'b0; bus2.d_min = '0; bus2.d_max = '0;

        tbl.push_back('{1,   20,  12'h020, 3'b011, 1'b0});
        tbl.push_back('{0,   127, 12'h128, 3'b111, 1'b0});
        tbl.push_back('{5,   5,   12'h001, 3'b001, 1'b0});
        tbl.push_back('{10,  3,   12'h000, 3'b000, 1'b1});
        tbl.push_back('{0,   0,   12'h001, 3'b001, 1'b0});
        tbl.push_back('{127, 127, 12'h001, 3'b001, 1'b0});
        tbl.push_back('{127, 0,   12'h000, 3'b000, 1'b1});
        tbl.push_back('{3,   12,  12'h010, 3'b011, 1'b0});
        tbl.push_back('{28,  126, 12'h099, 3'b011, 1'b0});

        #12;
        check("reset_bcd",  32'(bus1.bcd),  32'd0);
        check("reset_en",   32'(bus1.en),   32'd0);
        check("reset_err",  32'(bus1.err),  32'd0);
        check("reset_busy", 32'(bus1.busy), 32'd0);
        check("reset_done", 32'(bus1.done), 32'd0);
        check("reset_bcd2", 32'(bus2.bcd),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i])
            conv1($sformatf("vec%0d", i), tbl[i].dmin, tbl[i].dmax, tbl[i].bcd, tbl[i].en, tbl[i].err, 0);

        // Start pulse during busy with other bounds must be dropped.
        conv1("busy_ignore", 1, 100, 12'h100, 3'b111, 1'b0, 3);

        // Asynchronous reset in the middle of SHIFT.
        @(negedge clk);
        bus1.d_min = W1'(1); bus1.d_max = W1'(20); bus1.start = 1'b1;
        @(posedge clk); #1;
        bus1.start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_bcd",  32'(bus1.bcd),  32'd0);
        check("midreset_en",   32'(bus1.en),   32'd0);
        check("midreset_busy", 32'(bus1.busy), 32'd0);
        check("midreset_done", 32'(bus1.done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        n_bad = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk); #1;
            if (bus1.done) n_bad++;
        end
        check("midreset_no_done", 32'(n_bad), 32'd0);
        conv1("after_reset", 2, 51, 12'h050, 3'b011, 1'b0, 0);

        // start held high keeps re-arming the converter.
        @(negedge clk);
        bus1.d_min = W1'(3); bus1.d_max = W1'(50); bus1.start = 1'b1;
        n_done = 0; n_bad = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            if (bus1.done) begin
                n_done++;
                if (bus1.bcd !== 12'h048 || bus1.en !== 3'b011) n_bad++;
            end
        end
        check("hold_rearm", 32'(n_done >= 2), 32'd1);
        check("hold_results", 32'(n_bad), 32'd0);
        bus1.start = 1'b0;
        repeat (15) @(posedge clk);

        for (int i = 0; i < 30; i++) begin
            a = int'($urandom_range(0, 127));
            b = int'($urandom_range(0, 127));
            if (i % 3 != 0 && a > b) begin t = a; a = b; b = t; end
            model(a, b, N1, mb, me, mr);
            conv1($sformatf("rand%0d_%0d_%0d", i, a, b), a, b, mb[11:0], me[2:0], mr, 0);
        end

        conv2("w9_1_511", 1, 511);
        check("w9_1_511_exact", 32'(bus2.bcd), 32'h0511);
        conv2("w9_full", 0, 511);
        conv2("w9_err", 300, 2);
        for (int i = 0; i < 8; i++) begin
            a = int'($urandom_range(0, 511));
            b = int'($urandom_range(0, 511));
            if (i % 2 == 0 && a > b) begin t = a; a = b; b = t; end
            conv2($sformatf("w9_rand%0d", i), a, b);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
